mem_arbiter: RTL and testbench

Multicycle memory access sequencer and arbiter for the single shared 32-bit memory port. It arbitrates between the instruction-fetch requester (control unit fetch state) and the data requester (load/store states). It sequences each granted access through issue, fixed-latency wait and completion, then returns a one-cycle acknowledge with read data. It sits between the control unit and the memory, and is the only block allowed to drive the memory address and write strobe.

---
 rtl/mem_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Sequencer and arbiter for the single shared memory port. Two requesters
// compete for it: instruction fetch (read-only) and data (load or store).
// Each granted access walks IDLE -> ISSUE -> [WAIT x MEM_LAT] -> DONE. A
// one-cycle ACK goes to the granted requester in DONE. This block is the only
// driver of the memory address and write strobe.
//
// Ports
//   CLK, RESET          clock; synchronous active-high reset
//   IF_REQ / IF_ADDR    fetch read request and address (held until IF_ACK)
//   IF_ACK / IF_RDATA   fetch completion pulse and read data
//   D_REQ / D_WE        data request; D_WE=1 store, 0 load (held until D_ACK)
//   D_ADDR / D_WDATA    data address and store data
//   D_ACK / D_RDATA     data completion pulse and load data
//   MEM_ADDR/MEM_WDATA  registered memory address and write data
//   MEM_WE              memory write strobe, high only in ISSUE of a store
//   MEM_RDATA           memory read data, valid MEM_LAT cycles after ISSUE
//   BUSY / STATE        not-IDLE flag and raw state code for debug
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              IF_REQ,
  input  logic [ADDR_W-1:0] IF_ADDR,
  output logic              IF_ACK,
  output logic [DATA_W-1:0] IF_RDATA,
  input  logic              D_REQ,
  input  logic              D_WE,
  input  logic [ADDR_W-1:0] D_ADDR,
  input  logic [DATA_W-1:0] D_WDATA,
  output logic              D_ACK,
  output logic [DATA_W-1:0] D_RDATA,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic              MEM_WE,
  output logic [DATA_W-1:0] MEM_WDATA,
  input  logic [DATA_W-1:0] MEM_RDATA,
  output logic              BUSY,
  output logic [1:0]        STATE
);

  // Wide enough to hold MEM_LAT itself (MEM_LAT >= 1).
  localparam int CNT_W = $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              last_data_q, last_data_d;  // 1: previous grant went to data
  logic              gnt_data_q, gnt_data_d;    // 1: current access belongs to data
  logic              we_q, we_d;                // current access is a store
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Next-state and datapath logic.
  always_comb begin
    // NOTE: every signal gets a default before the case so that no path leaves
    // it unassigned; otherwise synthesis infers a latch to hold the old value.
    state_d     = state_q;
    last_data_d = last_data_q;
    gnt_data_d  = gnt_data_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    cnt_d       = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (IF_REQ || D_REQ) begin
          // Data wins when it is alone, or on a tie when fetch went last.
          gnt_data_d  = D_REQ && (!IF_REQ || !last_data_q);
          last_data_d = gnt_data_d;
          we_d        = gnt_data_d && D_WE;
          addr_d      = gnt_data_d ? D_ADDR : IF_ADDR;
          if (gnt_data_d) begin
            wdata_d = D_WDATA;
          end
          state_d = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        if (we_q) begin
          state_d = ST_DONE;
        end else begin
          cnt_d   = CNT_W'(MEM_LAT);
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        // Counter reaches 1 in the MEM_LAT-th WAIT cycle, when MEM_RDATA is valid.
        if (cnt_q == CNT_W'(1)) begin
          rdata_d = MEM_RDATA;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register with synchronous reset. An in-flight access is simply
  // dropped on reset; returning to IDLE suppresses its ACK.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (RESET) begin
      state_q     <= ST_IDLE;
      last_data_q <= 1'b0;
      gnt_data_q  <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      last_data_q <= last_data_d;
      gnt_data_q  <= gnt_data_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      cnt_q       <= cnt_d;
    end
  end

  // Outputs decode registered state only; no REQ input reaches an output
  // combinationally.
  assign MEM_ADDR  = addr_q;
  assign MEM_WDATA = wdata_q;
  assign MEM_WE    = (state_q == ST_ISSUE) && we_q;
  assign IF_ACK    = (state_q == ST_DONE) && !gnt_data_q;
  assign D_ACK     = (state_q == ST_DONE) && gnt_data_q;
  assign IF_RDATA  = rdata_q;
  assign D_RDATA   = rdata_q;
  assign BUSY      = (state_q != ST_IDLE);
  assign STATE     = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Self-checking bench for mem_arbiter. A transaction-timeline reference model
// (grant cycle t0, ISSUE at t0+1, capture at t0+1+LAT, ACK at t0+2 or
// t0+2+LAT) predicts every output each cycle. The bench also acts as the memory.
// It returns valid read data only in the cycle the model expects the capture,
// and the inverted word in every other cycle. A directed table and hand
// sequences cover reset, tie alternation, reset during WAIT and back-to-back
// loads. Random requesters follow.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic        if_ack, d_ack, mem_we, busy;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic [1:0]  state;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
    .CLK(clk), .RESET(rst),
    .IF_REQ(if_req), .IF_ADDR(if_addr), .IF_ACK(if_ack), .IF_RDATA(if_rdata),
    .D_REQ(d_req), .D_WE(d_we), .D_ADDR(d_addr), .D_WDATA(d_wdata),
    .D_ACK(d_ack), .D_RDATA(d_rdata),
    .MEM_ADDR(mem_addr), .MEM_WE(mem_we), .MEM_WDATA(mem_wdata),
    .MEM_RDATA(mem_rdata), .BUSY(busy), .STATE(state)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model: word-addressed memory plus one in-flight transaction.
  logic [31:0] mem [256];
  bit          m_active, m_is_data, m_we, m_last_data;
  int          m_k;                 // cycles since grant; 1 = ISSUE
  logic [31:0] m_addr, m_mem_addr, m_mem_wdata, m_rdata;

  bit prev_if_ack, prev_d_ack;
  int d_ack_cnt, last_d_ack_cyc;

  typedef struct {
    logic        rst, if_req;
    logic [31:0] if_addr;
    logic        d_req, d_we;
    logic [31:0] d_addr, d_wdata;
    logic [1:0]  e_state;
    logic        e_if_ack, e_d_ack, e_mem_we;
    logic [31:0] e_mem_addr, e_rdata;
  } vec_t;

  vec_t vt [15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_active    = 1'b0;
    m_is_data   = 1'b0;
    m_we        = 1'b0;
    m_k         = 0;
    m_last_data = 1'b0;
    m_addr      = '0;
    m_mem_addr  = '0;
    m_mem_wdata = '0;
    m_rdata     = '0;
  endtask

  // Called mid-cycle with this cycle's inputs already driven: serve memory,
  // compare outputs, advance the model across the next rising edge.
  task automatic tick();
    int          ak;
    logic [7:0]  idx;
    logic [1:0]  e_state;
    bit          e_issue_store;
    ak  = m_we ? 2 : 2 + LAT;
    idx = m_addr[9:2];
    mem_rdata = (m_active && !m_we && m_k == 1 + LAT) ? mem[idx] : ~mem[idx];
    e_issue_store = m_active && m_we && (m_k == 1);
    if (!m_active)       e_state = 2'd0;
    else if (m_k == 1)   e_state = 2'd1;
    else if (m_k == ak)  e_state = 2'd3;
    else                 e_state = 2'd2;

    check("state",    64'(state),    64'(e_state));
    check("busy",     64'(busy),     64'(m_active));
    check("if_ack",   64'(if_ack),   64'(m_active && m_k == ak && !m_is_data));
    check("d_ack",    64'(d_ack),    64'(m_active && m_k == ak && m_is_data));
    check("mem_we",   64'(mem_we),   64'(e_issue_store));
    check("mem_addr", 64'(mem_addr), 64'(m_mem_addr));
    check("if_rdata", 64'(if_rdata), 64'(m_rdata));
    check("d_rdata",  64'(d_rdata),  64'(m_rdata));
    if (e_issue_store) check("mem_wdata", 64'(mem_wdata), 64'(m_mem_wdata));

    prev_if_ack = (if_ack === 1'b1);
    prev_d_ack  = (d_ack === 1'b1);
    if (prev_d_ack) begin
      d_ack_cnt++;
      last_d_ack_cyc = cyc;
    end

    // The memory itself commits a strobed write even if reset hits that edge.
    if (e_issue_store) mem[idx] = m_mem_wdata;

    if (rst) begin
      model_reset();
    end else if (!m_active) begin
      if (if_req || d_req) begin
        m_is_data   = d_req && !(if_req && m_last_data);
        m_last_data = m_is_data;
        m_we        = m_is_data && d_we;
        m_addr      = m_is_data ? d_addr : if_addr;
        m_mem_addr  = m_addr;
        if (m_is_data) m_mem_wdata = d_wdata;
        m_active    = 1'b1;
        m_k         = 1;
      end
    end else if (m_k == ak) begin
      m_active = 1'b0;
      m_k      = 0;
    end else begin
      if (!m_we && m_k == 1 + LAT) m_rdata = mem[idx];
      m_k++;
    end

    @(negedge clk);
    cyc++;
  endtask

  initial begin
    int c0;
    int ack_cyc [3];

    for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 | i;
    mem[4] = 32'h00A0_0093;  // address 0x10

    // Directed table: {inputs} -> {expected outputs} for the same cycle.
    //            rst  ifr  if_addr  dr   dwe  d_addr   d_wdata        st    ia   da   we   mem_addr  rdata
    vt[0]  = '{1'b1, 1'b1, 32'h10, 1'b1, 1'b0, 32'h20, 32'h0,        2'd0, 1'b0, 1'b0, 1'b0, 32'h00, 32'h0};
    vt[1]  = '{1'b0, 1'b1, 32'h10, 1'b1, 1'b0, 32'h20, 32'h0,        2'd0, 1'b0, 1'b0, 1'b0, 32'h00, 32'h0};
    vt[2]  = '{1'b0, 1'b1, 32'h10, 1'b1, 1'b0, 32'h20, 32'h0,        2'd1, 1'b0, 1'b0, 1'b0, 32'h20, 32'h0};
    vt[3]  = '{1'b0, 1'b1, 32'h10, 1'b1, 1'b0, 32'h20, 32'h0,        2'd2, 1'b0, 1'b0, 1'b0, 32'h20, 32'h0};
    vt[4]  = '{1'b0, 1'b1, 32'h10, 1'b1, 1'b0, 32'h20, 32'h0,        2'd2, 1'b0, 1'b0, 1'b0, 32'h20, 32'h0};
    vt[5]  = '{1'b0, 1'b1, 32'h10, 1'b1, 1'b0, 32'h20, 32'h0,        2'd3, 1'b0, 1'b1, 1'b0, 32'h20, 32'hC0DE0008};
    vt[6]  = '{1'b0, 1'b1, 32'h10, 1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 2'd0, 1'b0, 1'b0, 1'b0, 32'h20, 32'hC0DE0008};
    vt[7]  = '{1'b0, 1'b1, 32'h10, 1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 2'd1, 1'b0, 1'b0, 1'b0, 32'h10, 32'hC0DE0008};
    vt[8]  = '{1'b0, 1'b1, 32'h10, 1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 2'd2, 1'b0, 1'b0, 1'b0, 32'h10, 32'hC0DE0008};
    vt[9]  = '{1'b0, 1'b1, 32'h10, 1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 2'd2, 1'b0, 1'b0, 1'b0, 32'h10, 32'hC0DE0008};
    vt[10] = '{1'b0, 1'b1, 32'h10, 1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 2'd3, 1'b1, 1'b0, 1'b0, 32'h10, 32'h00A00093};
    vt[11] = '{1'b0, 1'b0, 32'h10, 1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 2'd0, 1'b0, 1'b0, 1'b0, 32'h10, 32'h00A00093};
    vt[12] = '{1'b0, 1'b0, 32'h10, 1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 2'd1, 1'b0, 1'b0, 1'b1, 32'h40, 32'h00A00093};
    vt[13] = '{1'b0, 1'b0, 32'h10, 1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 2'd3, 1'b0, 1'b1, 1'b0, 32'h40, 32'h00A00093};
    vt[14] = '{1'b0, 1'b0, 32'h10, 1'b0, 1'b0, 32'h40, 32'h0,        2'd0, 1'b0, 1'b0, 1'b0, 32'h40, 32'h00A00093};

    // First reset edge with both requests high; outputs are unknown before it.
    rst = 1'b1; if_req = 1'b1; if_addr = 32'h10;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20; d_wdata = '0;
    mem_rdata = '0;
    model_reset();
    @(negedge clk);
    cyc = 1;

    for (int i = 0; i < 15; i++) begin
      rst = vt[i].rst; if_req = vt[i].if_req; if_addr = vt[i].if_addr;
      d_req = vt[i].d_req; d_we = vt[i].d_we; d_addr = vt[i].d_addr; d_wdata = vt[i].d_wdata;
      check("tbl_state",    64'(state),    64'(vt[i].e_state));
      check("tbl_busy",     64'(busy),     64'(vt[i].e_state != 2'd0));
      check("tbl_if_ack",   64'(if_ack),   64'(vt[i].e_if_ack));
      check("tbl_d_ack",    64'(d_ack),    64'(vt[i].e_d_ack));
      check("tbl_mem_we",   64'(mem_we),   64'(vt[i].e_mem_we));
      check("tbl_mem_addr", 64'(mem_addr), 64'(vt[i].e_mem_addr));
      check("tbl_rdata",    64'(d_rdata),  64'(vt[i].e_rdata));
      if (vt[i].e_mem_we) check("tbl_mem_wdata", 64'(mem_wdata), 64'(32'hDEADBEEF));
      tick();
    end

    // Reset in the second WAIT cycle of a load; the held request is re-served.
    c0 = cyc; d_ack_cnt = 0;
    if_req = 1'b0; d_we = 1'b0; d_addr = 32'h24; d_wdata = '0;
    for (int j = 0; j < 11; j++) begin
      rst   = (j == 3);
      d_req = (d_ack_cnt == 0);
      if (j == 4) check("rst_mid_state", 64'(state), 64'(0));
      tick();
    end
    check("rst_mid_ack_count", 64'(d_ack_cnt), 64'(1));
    check("rst_mid_ack_cycle", 64'(last_d_ack_cyc - c0), 64'(4 + 2 + LAT));
    check("rst_mid_rdata",     64'(d_rdata), 64'(32'hC0DE0009));

    // Back-to-back loads: D_REQ stays high, address advances after each ACK.
    c0 = cyc; d_ack_cnt = 0; rst = 1'b0; if_req = 1'b0; d_we = 1'b0;
    for (int j = 0; j < 18; j++) begin
      d_req  = (d_ack_cnt < 3);
      d_addr = 32'h30 + 32'(4 * d_ack_cnt);
      tick();
      if (prev_d_ack && d_ack_cnt <= 3) ack_cyc[d_ack_cnt-1] = last_d_ack_cyc;
    end
    check("b2b_ack_count", 64'(d_ack_cnt), 64'(3));
    check("b2b_first_ack", 64'(ack_cyc[0] - c0), 64'(2 + LAT));
    check("b2b_period_1",  64'(ack_cyc[1] - ack_cyc[0]), 64'(3 + LAT));
    check("b2b_period_2",  64'(ack_cyc[2] - ack_cyc[1]), 64'(3 + LAT));
    check("b2b_rdata",     64'(d_rdata), 64'(32'hC0DE000E));

    // Random requesters that obey the hold-until-ACK protocol, with rare resets.
    if_req = 1'b0; d_req = 1'b0; prev_if_ack = 1'b0; prev_d_ack = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (prev_if_ack) if_req = 1'b0;
      if (prev_d_ack)  d_req  = 1'b0;
      if (!if_req && $urandom_range(0, 3) == 0) begin
        if_req  = 1'b1;
        if_addr = {22'd0, 8'($urandom), 2'b00};
      end
      if (!d_req && $urandom_range(0, 3) == 0) begin
        d_req   = 1'b1;
        d_we    = 1'($urandom_range(0, 1));
        d_addr  = {22'd0, 8'($urandom), 2'b00};
        d_wdata = $urandom;
      end
      rst = ($urandom_range(0, 149) == 0);
      tick();
    end

    // Drain any in-flight access.
    rst = 1'b0; if_req = 1'b0; d_req = 1'b0;
    for (int n = 0; n < 10; n++) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
